// File: rtl/pe_ctrl_pkg.sv
// Shared types and default latency constants for the PE column sequencer.
// The total-latency helper keeps the top and its delay line in agreement.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } pe_ctrl_state_t;

  localparam int unsigned DEF_NUM_PE  = 9;
  localparam int unsigned DEF_MUL_LAT = 3;
  localparam int unsigned DEF_ADD_LAT = 3;
  localparam int unsigned DEF_LEN_W   = 16;

  // Operand register, then the multiplier, then one adder per PE down the column.
  function automatic int unsigned tot_lat(input int unsigned num_pe,
                                          input int unsigned mul_lat,
                                          input int unsigned add_lat);
    return 1 + mul_lat + num_pe * add_lat;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Single-bit shift register that tracks a fire through the FPU pipeline.
// Clearing it on reset guarantees no stale psum strobes after an aborted job.
module valid_delay_line #(
  parameter int unsigned DEPTH = 31
) (
  input  logic i_clk,
  input  logic i_rest_n,
  input  logic i_valid,
  output logic o_valid
);

  logic [DEPTH-1:0] stage_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge i_clk or negedge i_rest_n) begin
        if (!i_rest_n) stage_q <= '0;
        else           stage_q <= i_valid;
      end
    end else begin : g_chain
      always_ff @(posedge i_clk or negedge i_rest_n) begin
        if (!i_rest_n) stage_q <= '0;
        else           stage_q <= {stage_q[DEPTH-2:0], i_valid};
      end
    end
  endgenerate

  assign o_valid = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_col_ctrl.sv
// Sequencer for one column of FPU processing elements: weight load, fmap
// streaming, pipeline drain and psum-valid tracking. No datapath lives here.
module pe_col_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PE  = DEF_NUM_PE,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT,
  parameter int unsigned ADD_LAT = DEF_ADD_LAT,
  parameter int unsigned LEN_W   = DEF_LEN_W
) (
  input  logic              i_clk,
  input  logic              i_rest_n,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_cfg_len,
  input  logic              i_cfg_reuse_w,
  input  logic              i_w_valid,
  output logic              o_w_ready,
  output logic [NUM_PE-1:0] o_weight_en,
  input  logic              i_f_valid,
  output logic              o_f_ready,
  output logic              o_left_en,
  output logic              o_right_en,
  output logic              o_psum_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned TOT_LAT = tot_lat(NUM_PE, MUL_LAT, ADD_LAT);
  localparam int unsigned W_CNT_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int unsigned D_CNT_W = (TOT_LAT > 1) ? $clog2(TOT_LAT) : 1;

  localparam logic [W_CNT_W-1:0] W_LAST   = W_CNT_W'(NUM_PE - 1);
  localparam logic [D_CNT_W-1:0] D_LAST   = D_CNT_W'(TOT_LAT - 1);
  localparam logic [NUM_PE-1:0]  PE0_HOT  = NUM_PE'(1);

  pe_ctrl_state_t     state_q, state_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic [W_CNT_W-1:0] w_cnt_q, w_cnt_d;
  logic [LEN_W-1:0]   f_cnt_q, f_cnt_d;
  logic [D_CNT_W-1:0] d_cnt_q, d_cnt_d;
  logic               fire;

  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      w_cnt_q <= '0;
      f_cnt_q <= '0;
      d_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      w_cnt_q <= w_cnt_d;
      f_cnt_q <= f_cnt_d;
      d_cnt_q <= d_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    w_cnt_d     = w_cnt_q;
    f_cnt_d     = f_cnt_q;
    d_cnt_d     = d_cnt_q;
    o_w_ready   = 1'b0;
    o_weight_en = '0;
    o_f_ready   = 1'b0;
    o_left_en   = 1'b0;
    o_right_en  = 1'b0;
    o_done      = 1'b0;
    fire        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          len_d   = i_cfg_len;
          w_cnt_d = '0;
          f_cnt_d = '0;
          d_cnt_d = '0;
          if (!i_cfg_reuse_w)        state_d = LOAD_W;
          else if (i_cfg_len == '0)  state_d = DONE;
          else                       state_d = STREAM;
        end
      end

      LOAD_W: begin
        o_w_ready = 1'b1;
        if (i_w_valid) begin
          o_weight_en = PE0_HOT << w_cnt_q;
          if (w_cnt_q == W_LAST) state_d = (len_q == '0) ? DONE : STREAM;
          else                   w_cnt_d = w_cnt_q + W_CNT_W'(1);
        end
      end

      STREAM: begin
        o_f_ready = 1'b1;
        fire      = i_f_valid;
        if (fire) begin
          o_left_en  = 1'b1;
          o_right_en = 1'b1;
          // len is nonzero here, so len-1 cannot underflow.
          if (f_cnt_q == len_q - LEN_W'(1)) begin
            state_d = DRAIN;
            d_cnt_d = '0;
          end else begin
            f_cnt_d = f_cnt_q + LEN_W'(1);
          end
        end
      end

      DRAIN: begin
        if (d_cnt_q == D_LAST) state_d = DONE;
        else                   d_cnt_d = d_cnt_q + D_CNT_W'(1);
      end

      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_busy = (state_q != IDLE);

  valid_delay_line #(
    .DEPTH (TOT_LAT)
  ) u_psum_dly (
    .i_clk    (i_clk),
    .i_rest_n (i_rest_n),
    .i_valid  (fire),
    .o_valid  (o_psum_valid)
  );

endmodule

// File: tb/tb_pe_col_ctrl.sv
// Directed bench for pe_col_ctrl; psum strobes are matched against a queue of
// expected arrival cycles pushed whenever a fire is driven.
module tb_pe_col_ctrl;

  localparam int NUM_PE  = 9;
  localparam int TOT_LAT = 31;

  logic              i_clk = 1'b0;
  logic              i_rest_n;
  logic              i_start;
  logic [15:0]       i_cfg_len;
  logic              i_cfg_reuse_w;
  logic              i_w_valid;
  logic              o_w_ready;
  logic [NUM_PE-1:0] o_weight_en;
  logic              i_f_valid;
  logic              o_f_ready;
  logic              o_left_en;
  logic              o_right_en;
  logic              o_psum_valid;
  logic              o_busy;
  logic              o_done;

  int cyc = 0;
  int q[$];
  int tests_run = 0;
  int failures  = 0;
  int psum_seen = 0;
  int last_fire = 0;

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  pe_col_ctrl dut (
    .i_clk         (i_clk),
    .i_rest_n      (i_rest_n),
    .i_start       (i_start),
    .i_cfg_len     (i_cfg_len),
    .i_cfg_reuse_w (i_cfg_reuse_w),
    .i_w_valid     (i_w_valid),
    .o_w_ready     (o_w_ready),
    .o_weight_en   (o_weight_en),
    .i_f_valid     (i_f_valid),
    .o_f_ready     (o_f_ready),
    .o_left_en     (o_left_en),
    .o_right_en    (o_right_en),
    .o_psum_valid  (o_psum_valid),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock of stimulus; outputs are sampled 1 ns after the falling edge.
  task automatic step(input logic wv, input logic fv, input logic st,
                      input logic [15:0] len, input logic rw);
    int exp_c;
    @(negedge i_clk);
    i_w_valid     = wv;
    i_f_valid     = fv;
    i_start       = st;
    i_cfg_len     = len;
    i_cfg_reuse_w = rw;
    #1;
    if (o_psum_valid === 1'b1) begin
      psum_seen++;
      chk("psum_pending", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        exp_c = q.pop_front();
        chk("psum_cycle", cyc, exp_c);
      end
    end
    chk("rdy_excl", 32'(o_w_ready & o_f_ready), 0);
  endtask

  task automatic start_job(input logic [15:0] len, input logic rw);
    step(1'b0, 1'b0, 1'b1, len, rw);
  endtask

  task automatic fire_step(input logic fv, input string tag);
    step(1'b0, fv, 1'b0, 16'd0, 1'b0);
    chk({tag, "_frdy"}, o_f_ready, 1);
    chk({tag, "_left"}, o_left_en, fv);
    chk({tag, "_right"}, o_right_en, fv);
    if (fv) begin
      q.push_back(cyc + TOT_LAT);
      last_fire = cyc;
    end
  endtask

  task automatic wait_done(input int exp_cyc, input string tag);
    int found;
    found = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      if (o_done === 1'b1) found = 1;
    end
    chk({tag, "_done_seen"}, found, 1);
    chk({tag, "_done_cyc"}, cyc, exp_cyc);
    chk({tag, "_q_empty"}, q.size(), 0);
    step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk({tag, "_idle_busy"}, o_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int done_seen;
    logic [31:0] one;
    one = 32'd1;

    i_rest_n = 1'b0; i_start = 1'b0; i_cfg_len = '0; i_cfg_reuse_w = 1'b0;
    i_w_valid = 1'b0; i_f_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_wen", o_weight_en, 0);
    chk("rst_wrdy", o_w_ready, 0);
    chk("rst_frdy", o_f_ready, 0);
    chk("rst_psum", o_psum_valid, 0);
    @(negedge i_clk);
    i_rest_n = 1'b1;

    // T1: full job, len=4, weights loaded back to back
    psum_seen = 0;
    start_job(16'd4, 1'b0);
    for (int k = 0; k < NUM_PE; k++) begin
      step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      chk("t1_wen", o_weight_en, one << k);
      chk("t1_wrdy", o_w_ready, 1);
    end
    for (int k = 0; k < 4; k++) fire_step(1'b1, "t1");
    wait_done(last_fire + TOT_LAT + 1, "t1");
    chk("t1_psum_cnt", psum_seen, 4);

    // T2: bubbles in the fmap stream
    psum_seen = 0;
    start_job(16'd3, 1'b1);
    fire_step(1'b1, "t2");
    fire_step(1'b0, "t2");
    fire_step(1'b1, "t2");
    fire_step(1'b0, "t2");
    fire_step(1'b1, "t2");
    wait_done(last_fire + TOT_LAT + 1, "t2");
    chk("t2_psum_cnt", psum_seen, 3);

    // T3: weight reuse, weight bus held valid to prove it is ignored
    psum_seen = 0;
    start_job(16'd2, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 1'b0, 16'd0, 1'b0);
      chk("t3_wrdy", o_w_ready, 0);
      chk("t3_wen", o_weight_en, 0);
      chk("t3_frdy", o_f_ready, 1);
      chk("t3_left", o_left_en, 1);
      q.push_back(cyc + TOT_LAT);
      last_fire = cyc;
    end
    wait_done(last_fire + TOT_LAT + 1, "t3");
    chk("t3_psum_cnt", psum_seen, 2);

    // T4: len=0 with weight load
    psum_seen = 0;
    start_job(16'd0, 1'b0);
    for (int k = 0; k < NUM_PE; k++) begin
      step(1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
      chk("t4_wen", o_weight_en, one << k);
    end
    step(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    chk("t4_done", o_done, 1);
    chk("t4_frdy", o_f_ready, 0);
    chk("t4_left", o_left_en, 0);
    repeat (TOT_LAT + 4) step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("t4_psum_cnt", psum_seen, 0);
    chk("t4_busy", o_busy, 0);

    // T5: weight valid toggling every cycle
    psum_seen = 0;
    start_job(16'd1, 1'b0);
    for (int k = 0; k < 2 * NUM_PE; k++) begin
      v = k % 2;
      step(v[0], 1'b0, 1'b0, 16'd0, 1'b0);
      chk("t5_wen", o_weight_en, (v != 0) ? (one << (k / 2)) : 32'd0);
      chk("t5_wrdy", o_w_ready, 1);
    end
    fire_step(1'b1, "t5");
    wait_done(last_fire + TOT_LAT + 1, "t5");
    chk("t5_psum_cnt", psum_seen, 1);

    // T6: reset in the middle of streaming
    start_job(16'd5, 1'b1);
    fire_step(1'b1, "t6");
    fire_step(1'b1, "t6");
    step(1'b0, 1'b1, 1'b0, 16'd0, 1'b0);
    chk("t6_pre_left", o_left_en, 1);
    #2 i_rest_n = 1'b0;
    #1;
    chk("t6_rst_left", o_left_en, 0);
    chk("t6_rst_frdy", o_f_ready, 0);
    chk("t6_rst_busy", o_busy, 0);
    chk("t6_rst_done", o_done, 0);
    q.delete();
    @(negedge i_clk);
    i_f_valid = 1'b0;
    @(negedge i_clk);
    i_rest_n = 1'b1;
    psum_seen = 0;
    done_seen = 0;
    for (int k = 0; k < TOT_LAT + 9; k++) begin
      step(1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
      if (o_done === 1'b1) done_seen = 1;
    end
    chk("t6_no_done", done_seen, 0);
    chk("t6_no_psum", psum_seen, 0);
    start_job(16'd1, 1'b1);
    fire_step(1'b1, "t6b");
    wait_done(last_fire + TOT_LAT + 1, "t6b");
    chk("t6b_psum_cnt", psum_seen, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
